// File: rtl/inst_mem_prog.sv
// rtl/inst_mem_prog.sv - writable instruction memory with program loader and stall-aware fetch port
//
// A loader streams a program into RAM one word per handshake. The fetch port
// returns the addressed word one cycle after the request. Fetches beyond the
// loaded program, or made before a program is complete, return NOP_WORD.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   ld_start     start or restart a program load (wins over ld_valid)
//   ld_valid     ld_data carries a word
//   ld_data      program word to store
//   ld_last      marks the final word of the program
//   ld_ready     loader accepts a word this cycle
//   loading      loader FSM is in LOAD
//   prog_words   number of words loaded so far (ADDR_W+1 bits, max DEPTH)
//   fetch_en     fetch request
//   fetch_addr   word address to fetch
//   stall        hold inst / inst_valid / addr_err
//   inst         fetched instruction (registered)
//   inst_valid   inst holds a valid fetch result
//   addr_err     last fetch was outside [0, prog_words)

module inst_mem_prog #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              loading,
  output logic [ADDR_W:0]   prog_words,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err
);

  // RAM index width; the fetch index is only used once the range check has
  // proven fetch_addr < prog_words <= DEPTH, so the low bits are sufficient.
  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   wptr, wptr_n;
  logic              we;
  logic              in_range;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] mem [DEPTH];

  // The write pointer doubles as the loaded-word count: it only advances on
  // accepted words and stops at DEPTH because the FSM leaves LOAD there.
  assign prog_words = wptr;
  assign in_range   = {1'b0, fetch_addr} < wptr;
  assign raddr      = fetch_addr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wptr  <= '0;
    end else begin
      state <= state_n;
      wptr  <= wptr_n;
    end
  end

  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    we       = 1'b0;
    ld_ready = 1'b0;
    loading  = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        loading  = 1'b1;
        if (ld_start) begin
          // restart; a word offered alongside ld_start is dropped
          wptr_n = '0;
        end else if (ld_valid) begin
          we     = 1'b1;
          wptr_n = wptr + 1'b1;
          if (ld_last || wptr == LAST_IDX) state_n = READY;
        end
      end
      READY: begin
        if (ld_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM is deliberately not reset; prog_words gates what is readable.
  always_ff @(posedge clk) begin
    if (we) mem[wptr[AW-1:0]] <= ld_data;
  end

  // Fetch only serves data in READY, so a fetch coinciding with the final
  // write of a load sees the pre-write FSM state and returns NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (!stall) begin
      if (fetch_en) begin
        if (state == READY) begin
          inst_valid <= 1'b1;
          if (in_range) begin
            inst     <= mem[raddr];
            addr_err <= 1'b0;
          end else begin
            inst     <= NOP_WORD;
            addr_err <= 1'b1;
          end
        end else begin
          inst       <= NOP_WORD;
          inst_valid <= 1'b0;
          addr_err   <= 1'b0;
        end
      end else begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_prog.sv
// tb/tb_inst_mem_prog.sv - self-checking bench for inst_mem_prog
module tb_inst_mem_prog;
  localparam int DW    = 16;
  localparam int AWD   = 16;
  localparam int DEPTH = 1024;
  localparam logic [DW-1:0] NOP = 16'h0000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [DW-1:0]  ld_data = '0;
  logic           ld_ready, loading;
  logic [AWD:0]   prog_words;
  logic           fetch_en = 1'b0, stall = 1'b0;
  logic [AWD-1:0] fetch_addr = '0;
  logic [DW-1:0]  inst;
  logic           inst_valid, addr_err;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  inst_mem_prog #(.DATA_W(DW), .ADDR_W(AWD), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .loading(loading), .prog_words(prog_words),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .stall(stall),
    .inst(inst), .inst_valid(inst_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a program is a list of words plus a "being loaded" /
  // "complete" status; fetches see the program as it stood before the edge.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy, m_done;
  int            m_words;
  logic [DW-1:0] m_inst;
  bit            m_iv, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_words = 0;
      m_inst = NOP; m_iv = 0; m_err = 0;
    end else begin
      if (!stall) begin
        if (fetch_en && m_done) begin
          m_iv = 1;
          if (int'(fetch_addr) < m_words) begin m_inst = m_mem[int'(fetch_addr)]; m_err = 0; end
          else begin m_inst = NOP; m_err = 1; end
        end else if (fetch_en) begin
          m_inst = NOP; m_iv = 0; m_err = 0;
        end else begin
          m_iv = 0;
        end
      end
      if (ld_start) begin
        m_busy = 1; m_done = 0; m_words = 0;
      end else if (m_busy && ld_valid) begin
        m_mem[m_words] = ld_data;
        m_words++;
        if (ld_last || m_words == DEPTH) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_inst", 32'(inst), 32'(m_inst));
      chk("cyc_inst_valid", 32'(inst_valid), 32'(m_iv));
      chk("cyc_addr_err", 32'(addr_err), 32'(m_err));
      chk("cyc_prog_words", 32'(prog_words), 32'(m_words));
      chk("cyc_loading", 32'(loading), 32'(m_busy));
      chk("cyc_ld_ready", 32'(ld_ready), 32'(m_busy));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] prog_word(input int i);
    return 16'h9205 + 16'(i * 3);
  endfunction

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    check_en = 1'b1;
    cyc();

    // T1: reset asserted mid-cycle clears outputs immediately
    #2 rst_n = 1'b0;
    #1;
    chk("t1_inst", 32'(inst), 32'h0000);
    chk("t1_inst_valid", 32'(inst_valid), 0);
    chk("t1_prog_words", 32'(prog_words), 0);
    chk("t1_loading", 32'(loading), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // T2: load 40 words, fetch address 0
    ld_start = 1; cyc(); ld_start = 0;
    for (int i = 0; i < 40; i++) begin
      ld_valid = 1; ld_data = prog_word(i); ld_last = (i == 39);
      cyc();
    end
    ld_valid = 0; ld_last = 0;
    chk("t2_prog_words", 32'(prog_words), 40);
    chk("t2_loading", 32'(loading), 0);
    fetch_en = 1; fetch_addr = 0; cyc();
    chk("t2_inst", 32'(inst), 32'h9205);
    chk("t2_inst_valid", 32'(inst_valid), 1);

    // T3: out-of-range fetches
    fetch_addr = 40; cyc();
    chk("t3_inst_40", 32'(inst), 32'h0000);
    chk("t3_err_40", 32'(addr_err), 1);
    chk("t3_iv_40", 32'(inst_valid), 1);
    fetch_addr = 16'hFFFF; cyc();
    chk("t3_inst_ffff", 32'(inst), 32'h0000);
    chk("t3_err_ffff", 32'(addr_err), 1);
    chk("t3_iv_ffff", 32'(inst_valid), 1);

    // T4: stall holds mem[1]; mem[2] follows once stall drops
    fetch_addr = 1; cyc();
    chk("t4_inst_1", 32'(inst), 32'h9208);
    stall = 1; fetch_addr = 2;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_hold", 32'(inst), 32'h9208);
      chk("t4_hold_err", 32'(addr_err), 0);
    end
    stall = 0; cyc();
    chk("t4_inst_2", 32'(inst), 32'h920B);
    fetch_en = 0; cyc();
    chk("t4_iv_drop", 32'(inst_valid), 0);
    chk("t4_inst_keep", 32'(inst), 32'h920B);

    // T5: restart mid-load, then fill to DEPTH without ld_last
    ld_start = 1; cyc(); ld_start = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1; ld_data = 16'hA000 + 16'(i); cyc();
    end
    ld_start = 1; ld_data = 16'hBEEF; cyc(); ld_start = 0;
    chk("t5_restart_words", 32'(prog_words), 0);
    chk("t5_restart_loading", 32'(loading), 1);
    fetch_en = 1; fetch_addr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1; ld_data = 16'h1000 + 16'(i); cyc();
    end
    chk("t5_fill_words", 32'(prog_words), DEPTH);
    chk("t5_fill_ready", 32'(ld_ready), 0);
    chk("t5_last_fetch_nop", 32'(inst_valid), 0);
    ld_data = 16'h5555; cyc();
    ld_valid = 0;
    chk("t5_no_extra", 32'(prog_words), DEPTH);
    chk("t5_first", 32'(inst), 32'h1000);
    fetch_addr = DEPTH - 1; cyc();
    chk("t5_top", 32'(inst), 32'h13FF);
    fetch_addr = DEPTH; cyc();
    chk("t5_oob_err", 32'(addr_err), 1);
    fetch_en = 0; cyc();

    // T6: reset during load; partial program unreadable
    ld_start = 1; cyc(); ld_start = 0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1; ld_data = 16'hC000 + 16'(i); cyc();
    end
    ld_valid = 0;
    #2 rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    fetch_en = 1; fetch_addr = 3; cyc();
    chk("t6_inst", 32'(inst), 32'h0000);
    chk("t6_iv", 32'(inst_valid), 0);
    chk("t6_words", 32'(prog_words), 0);
    fetch_en = 0;
    repeat (2) cyc();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
